// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Pulls one word at a time from a FIFO read port and sends it on a serial
//   line. Each frame is a start bit (0), the data bits LSB first, an even
//   parity bit and a stop bit (1). Every bit is held for CLKS_PER_BIT cycles.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        synchronous active-low reset
//   enable       permits new FIFO reads and frame starts
//   fifo_empty   FIFO read-side empty flag
//   fifo_rd_en   registered one-cycle read request (high only in REQ)
//   fifo_rdata   FIFO read data, valid the cycle after fifo_rd_en
//   tx           registered serial line, idle high
//   busy         high whenever the FSM is not idle
//   frame_done   one-cycle pulse in the idle cycle after each stop bit
//   frame_count  completed frames, wraps 255 -> 0
module fifo_serial_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, REQ, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [WIDTH-1:0]   shreg;
  logic               par;
  logic               tx_d;
  logic               cnt_last;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    cnt_last = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    case (state)
      IDLE:   if (enable && !fifo_empty) state_d = REQ;
      REQ:    state_d = LOAD;
      LOAD: begin
        state_d = START;
        cnt_d   = '0;
        idx_d   = '0;
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (idx == IDX_W'(WIDTH - 1)) begin
            state_d = PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered. The
    // shift register is loaded on the LOAD->START edge, before DATA needs it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg[idx_d];
      PARITY:  tx_d = par;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tx          <= 1'b1;
      fifo_rd_en  <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      tx         <= tx_d;
      fifo_rd_en <= (state_d == REQ);
      frame_done <= (state == STOP) && (state_d == IDLE);
      if ((state == STOP) && (state_d == IDLE))
        frame_count <= frame_count + 8'd1;
      // Read data arrives in LOAD; it is ignored at all other times.
      if (state == LOAD) begin
        shreg <= fifo_rdata;
        par   <= even_parity(fifo_rdata);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

  localparam int W   = 4;
  localparam int CPB = 4;
  localparam int NB  = W + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic [W-1:0] fifo_rdata = '0;
  logic         tx;
  logic         busy;
  logic         frame_done;
  logic [7:0]   frame_count;

  int checks = 0;
  int errors = 0;

  // Simple FIFO model: words are written by the stimulus, read on fifo_rd_en.
  logic [W-1:0] mem [0:1023];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           rd_count = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cnt = 0;
  int           frames = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
      rd_count   <= rd_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Called at a negedge where no read is pending. Follows one whole frame
  // and returns at the negedge of the frame_done cycle.
  task automatic run_frame(input bit b2b, input int drop_at);
    logic [W-1:0]  w;
    logic [NB-1:0] bits;
    int            waited;
    bit            bad_rd, bad_busy;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 1, 0);
      return;
    end
    w        = exp_q.pop_front();
    bits     = {1'b1, ^w, w, 1'b0};
    waited   = 0;
    bad_rd   = 0;
    bad_busy = 0;
    while (!fifo_rd_en && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!fifo_rd_en) begin
      check_val("rd_timeout", 0, 1);
      return;
    end
    if (b2b) check_val("gap", waited, 1);
    check_val("busy_req", busy, 1);
    @(negedge clk);
    check_val("tx_load", tx, 1);
    check_val("rd_once", fifo_rd_en, 0);
    check_val("done_low", frame_done, 0);
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      check_val($sformatf("tx_bit%0d", k), tx, bits[k / CPB]);
      if (fifo_rd_en) bad_rd = 1;
      if (!busy || frame_done) bad_busy = 1;
    end
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    frames++;
    check_val("frame_done", frame_done, 1);
    check_val("frame_count", frame_count, exp_cnt);
    check_val("tx_idle", tx, 1);
    check_val("busy_idle", busy, 0);
    check_val("no_rd_in_frame", bad_rd, 0);
    check_val("busy_in_frame", bad_busy, 0);
  endtask

  initial begin
    int base, n, waited;
    bit bad;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_rd", fifo_rd_en, 0);
    check_val("rst_done", frame_done, 0);
    check_val("rst_count", frame_count, 0);

    // Reset during data bit 2 aborts the frame
    rst_n  = 1'b1;
    enable = 1'b1;
    push(4'h0);
    waited = 0;
    while (!fifo_rd_en && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_val("abort_rd", fifo_rd_en, 1);
    repeat (15) @(negedge clk);
    check_val("abort_pre_tx", tx, 0);
    check_val("abort_pre_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_tx", tx, 1);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", frame_done, 0);
    check_val("abort_count", frame_count, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (frame_done || !tx || busy) bad = 1;
    end
    check_val("abort_quiet", bad, 0);
    check_val("abort_reads", rd_count, 1);

    // Directed words
    push(4'hA); run_frame(0, -1);
    push(4'h7); run_frame(0, -1);
    push(4'h0); run_frame(0, -1);

    // Three queued words back to back
    base = rd_count;
    push(4'h3); push(4'hC); push(4'h5);
    run_frame(0, -1); run_frame(1, -1); run_frame(1, -1);
    check_val("three_reads", rd_count - base, 3);

    // enable low holds off reads; drop enable mid-data
    enable = 1'b0;
    push(4'h9); push(4'h6);
    base = rd_count;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_rd_en || !tx || busy) bad = 1;
    end
    check_val("hold_off", bad, 0);
    check_val("hold_reads", rd_count - base, 0);
    enable = 1'b1;
    run_frame(0, 6);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (fifo_rd_en || !tx || busy) bad = 1;
    end
    check_val("after_drop", bad, 0);
    check_val("drop_reads", rd_count - base, 1);
    check_val("drop_nonempty", fifo_empty, 0);
    enable = 1'b1;
    run_frame(0, -1);

    // Random batches until frame_count has wrapped
    while (frames < 262) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) push(W'($urandom));
      for (int i = 0; i < n; i++) run_frame(i != 0, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check_val("wrap_count", frame_count, frames % 256);
    check_val("total_reads", rd_count, frames + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the FIFO data word width in bits.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4 (minimum 2), giving clk cycles per serial bit.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 enable  input  1  high permits new FIFO reads and frame starts.
REQ-007 fifo_empty  input  1  FIFO read-side empty flag.
REQ-008 fifo_rd_en  output  1  registered one-cycle read request to the FIFO.
REQ-009 fifo_rdata  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en is high.
REQ-010 tx  output  1  registered serial line, idle high.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 frame_done  output  1  one-cycle pulse after each completed stop bit.
REQ-013 frame_count  output  8  count of completed frames, wraps 255 -> 0.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE -> REQ when enable=1 and fifo_empty=0 at a rising edge; otherwise remain IDLE.
REQ-016 fifo_rd_en SHALL be 1 exactly during REQ (one cycle per frame) and 0 in every other state.
REQ-017 REQ -> LOAD unconditionally; at the edge leaving LOAD, fifo_rdata SHALL be captured into the shift register and parity = XOR of the captured bits (even parity).
REQ-018 LOAD -> START; START, each DATA bit, PARITY and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter reset at each state/bit change.
REQ-019 tx values: IDLE/REQ/LOAD = 1; START = 0; DATA = captured bits LSB first, WIDTH bits; PARITY = parity bit; STOP = 1.
REQ-020 Framed line time SHALL be (WIDTH+3)*CLKS_PER_BIT cycles (28 at defaults), START through STOP.
REQ-021 STOP -> IDLE after its last cycle; frame_done SHALL be 1 in that first IDLE cycle only, and frame_count SHALL increment by 1 on the same edge, modulo 256.
REQ-022 The frame_done IDLE cycle SHALL itself evaluate REQ-015, so back-to-back frames have exactly 3 tx-high cycles (IDLE, REQ, LOAD) between STOP end and next START.
REQ-023 enable or fifo_empty changing after REQ SHALL NOT affect the current frame; it always completes.
REQ-024 fifo_rdata SHALL be ignored except in LOAD; changes during a frame SHALL NOT alter tx.
REQ-025 No read SHALL be issued while busy=1 outside REQ; at most one word is consumed per frame.

Reset
REQ-026 With rst_n=0 at a rising edge: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, frame_count=0, shift register and counters 0.
REQ-027 Reset asserted mid-frame SHALL abort it: no frame_done, no count increment, tx=1 from the next cycle; the word already read is discarded.
REQ-028 After rst_n returns to 1, the first REQ SHALL occur no earlier than the first edge with rst_n=1, enable=1, fifo_empty=0.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles -> tx=1, busy=0, fifo_rd_en=0, frame_done=0, frame_count=0.
REQ-030 Single word 4'hA, defaults -> one fifo_rd_en pulse; tx = 0,0,1,0,1,0,1 (start, d0..d3, parity, stop) each held 4 cycles; one frame_done; frame_count=1.
REQ-031 Word 4'h7 -> data bits 1,1,1,0, parity bit 1; word 4'h0 -> parity 0; stop=1 in both.
REQ-032 Three words queued, fifo_empty=0 throughout, enable=1 -> exactly 3 fifo_rd_en pulses, 3-cycle high gap between frames, frame_count=3, data order preserved.
REQ-033 enable=0 with fifo_empty=0 for 20 cycles -> no fifo_rd_en, tx=1; enable dropped in DATA -> frame completes with frame_done, no further reads.
REQ-034 rst_n=0 during DATA bit 2 -> tx=1 next cycle, no frame_done, frame_count=0; 256 completed frames -> frame_count wraps to 0.
